// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// The FSM encoding is fixed so other blocks and waveforms can rely on it.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

endpackage

// File: rtl/piso_bitcnt.sv
// Frame bit counter: clears on a new word, advances on each shifted bit and
// saturates at WIDTH-1 so it can never point past the last bit.
module piso_bitcnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic zero_o,
    output logic tc_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign tc_o   = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready word loading, shift stall,
// per-bit first/done framing and gap-free back-to-back streaming.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             first,
    output logic             done
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic in_shift;
    logic accept;
    logic cnt_zero;
    logic cnt_tc;
    logic cnt_clear;
    logic cnt_en;
    logic out_bit;

    assign in_shift   = (state_q == SHIFT);
    assign done       = in_shift && cnt_tc;
    assign first      = in_shift && cnt_zero;
    // Ready during the last bit lets the next word follow with no idle gap.
    assign load_ready = !rst && (!in_shift || (done && shift_en));
    assign accept     = load_valid && load_ready;

    assign out_bit    = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sout       = in_shift && out_bit;
    assign sout_valid = in_shift;

    assign cnt_clear  = accept || (done && shift_en);
    assign cnt_en     = in_shift && shift_en && !cnt_tc;

    piso_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .zero_o  (cnt_zero),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = d;
        end else if (in_shift && shift_en) begin
            shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
            if (cnt_tc) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a cycle vector table for plain frames plus
// scoreboarded sequences for streaming, stall and mid-frame reset.
module tb_piso_tx;

    localparam int W = 8;

    typedef struct {
        logic         rst;
        logic         lv;
        logic         se;
        logic [W-1:0] d;
        logic         rdy;
        logic         sv;
        logic         so_m;
        logic         so_l;
        logic         fst;
        logic         dn;
    } vec_t;

    typedef struct {
        logic sout;
        logic first;
        logic done;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d;
    logic         load_valid;
    logic         shift_en;

    logic rdy_m, sv_m, so_m, f_m, dn_m;
    logic rdy_l, sv_l, so_l, f_l, dn_l;

    int n_checks = 0;
    int n_errors = 0;
    bit sb_en    = 1'b0;

    vec_t     vecs[$];
    exp_bit_t exp_m[$];
    exp_bit_t exp_l[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .shift_en   (shift_en),
        .sout       (so_m),
        .sout_valid (sv_m),
        .first      (f_m),
        .done       (dn_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .shift_en   (shift_en),
        .sout       (so_l),
        .sout_valid (sv_l),
        .first      (f_l),
        .done       (dn_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input logic r, input logic lv, input logic se,
                                    input logic [W-1:0] dd, input logic rdy, input logic sv,
                                    input logic som, input logic sol, input logic f, input logic dn);
        vecs.push_back('{r, lv, se, dd, rdy, sv, som, sol, f, dn});
    endfunction

    // bm/bl list the expected serial bits in emission order, leftmost first.
    function automatic void add_frame(input logic [W-1:0] dd, input logic [W-1:0] bm,
                                      input logic [W-1:0] bl);
        add_vec(1'b0, 1'b1, 1'b1, dd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) begin
            add_vec(1'b0, 1'b0, 1'b1, dd, (k == W - 1), 1'b1, bm[W-1-k], bl[W-1-k],
                    (k == 0), (k == W - 1));
        end
        add_vec(1'b0, 1'b0, 1'b1, dd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Expected frame for a word: bit order chosen per instance, framing flags by position.
    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_m.push_back('{w[W-1-i], (i == 0), (i == W - 1)});
            exp_l.push_back('{w[i], (i == 0), (i == W - 1)});
        end
    endfunction

    // A bit is consumed when it is presented while shift_en is high.
    always @(negedge clk) begin
        if (sb_en) begin
            if (sv_m) begin
                if (exp_m.size() == 0) begin
                    check("sb_m_extra", 32'(sv_m), 32'd0);
                end else begin
                    check("sb_m_bit", {so_m, f_m, dn_m},
                          {exp_m[0].sout, exp_m[0].first, exp_m[0].done});
                    if (shift_en) void'(exp_m.pop_front());
                end
            end
            if (sv_l) begin
                if (exp_l.size() == 0) begin
                    check("sb_l_extra", 32'(sv_l), 32'd0);
                end else begin
                    check("sb_l_bit", {so_l, f_l, dn_l},
                          {exp_l[0].sout, exp_l[0].first, exp_l[0].done});
                    if (shift_en) void'(exp_l.pop_front());
                end
            end
        end
    end

    task automatic offer(input logic [W-1:0] w);
        d          = w;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        push_word(w);
        @(negedge clk);
        check("offer_ready", {rdy_m, rdy_l}, 2'b11);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic frame_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, {sv_m, sv_l}, 2'b11);
            tick();
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check(name, {sv_m, sv_l, so_m, so_l, rdy_m, rdy_l}, 6'b000011);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        d          = '0;
        load_valid = 1'b0;
        shift_en   = 1'b0;

        // Reset and first idle cycle
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outputs", {rdy_m, sv_m, so_m, f_m, dn_m, rdy_l, sv_l, so_l, f_l, dn_l}, 10'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {rdy_m, rdy_l, sv_m, sv_l, so_m, so_l}, 6'b110000);
        tick();

        // Table-driven single frames: 8'h96 and 8'hA5 in both bit orders
        add_frame(8'h96, 8'b1001_0110, 8'b0110_1001);
        add_frame(8'hA5, 8'b1010_0101, 8'b1010_0101);
        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            load_valid = vecs[i].lv;
            shift_en   = vecs[i].se;
            d          = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {rdy_m, rdy_l, sv_m, sv_l, so_m, so_l, f_m, f_l, dn_m, dn_l},
                  {vecs[i].rdy, vecs[i].rdy, vecs[i].sv, vecs[i].sv, vecs[i].so_m,
                   vecs[i].so_l, vecs[i].fst, vecs[i].fst, vecs[i].dn, vecs[i].dn});
            tick();
        end

        sb_en = 1'b1;

        // Back-to-back: load_valid held high, second word taken in the done cycle
        offer(8'hF0);
        load_valid = 1'b1;
        d          = 8'h0F;
        push_word(8'h0F);
        frame_cycles("b2b_word1_valid", W);
        load_valid = 1'b0;
        frame_cycles("b2b_word2_valid", W);
        idle_check("b2b_idle");

        // Stall for three cycles while bit 3 is on the line; d changes must not leak in
        offer(8'hC9);
        frame_cycles("stall_pre", 2);
        shift_en = 1'b0;
        d        = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", {rdy_m, rdy_l}, 2'b00);
            check("stall_hold", {sv_m, sv_l, so_m, so_l}, 4'b1100);
            tick();
        end
        shift_en = 1'b1;
        frame_cycles("stall_post", 6);
        idle_check("stall_idle");

        // Reset pulsed during bit 5, then a fresh word
        offer(8'h5A);
        frame_cycles("rst_mid_pre", 4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {rdy_m, sv_m, so_m, f_m, dn_m, rdy_l, sv_l, so_l, f_l, dn_l}, 10'd0);
        exp_m.delete();
        exp_l.delete();
        tick();
        rst = 1'b0;
        offer(8'h3C);
        frame_cycles("rst_mid_new", W);
        idle_check("rst_mid_idle");

        check("sb_m_drain", exp_m.size(), 32'd0);
        check("sb_l_drain", exp_l.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift d[WIDTH-1] first and 0 = shift d[0] first.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port d  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port load_valid  input  1  d is valid this cycle.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port shift_en  input  1  advance serial output when high, stall when low.
REQ-009 SHALL have port sout  output  1  serial data bit.
REQ-010 SHALL have port sout_valid  output  1  sout carries a frame bit.
REQ-011 SHALL have port first  output  1  current sout is bit 0 of the frame.
REQ-012 SHALL have port done  output  1  current sout is the last bit of the frame.

Function
REQ-013 SHALL implement two states, IDLE and SHIFT.
REQ-014 SHALL define the accept condition as load_valid && load_ready sampled at posedge clk; at accept, d is captured into the shift register, the bit counter clears to 0 and the state becomes SHIFT.
REQ-015 SHALL present the first frame bit on sout with sout_valid=1 and first=1 in the cycle immediately after accept (latency 1).
REQ-016 SHALL, in SHIFT with shift_en=1, advance to the next bit and increment the counter on each posedge.
REQ-017 SHALL, in SHIFT with shift_en=0, hold sout, counter, first and done unchanged.
REQ-018 SHALL assert done combinationally while the counter equals WIDTH-1 in SHIFT; first is asserted only while the counter equals 0.
REQ-019 SHALL size the counter to $clog2(WIDTH) bits and never let it exceed WIDTH-1.
REQ-020 SHALL drive load_ready = (state==IDLE) || (done && shift_en), and 0 while rst is high.
REQ-021 SHALL, on accept during the done cycle, output the new word's first bit on the next cycle with no gap (back-to-back streaming).
REQ-022 SHALL return to IDLE after the done cycle when shift_en=1 and no accept occurs.
REQ-023 SHALL, in IDLE, drive sout=0, sout_valid=0, first=0 and done=0.
REQ-024 SHALL ignore load_valid while load_ready=0; d changes in SHIFT SHALL NOT affect the frame in flight.

Reset
REQ-025 SHALL, on rst assertion at any time including mid-frame, immediately force state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, first=0, done=0 and load_ready=0.
REQ-026 SHALL discard any partially transmitted frame on reset, with no resumption.
REQ-027 SHALL raise load_ready in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, SHIFT=1) in the shared package piso_pkg; WIDTH and MSB_FIRST remain module parameters.
REQ-029 SHALL implement the bit counter as sub-module piso_bitcnt (clear, enable, terminal-count output).
REQ-030 SHALL be 120-400 lines of RTL with no multicycle paths.

Verification
REQ-031 SHALL verify reset idle: rst=1 then rst=0 -> load_ready=1, sout_valid=0 and sout=0 in the next cycle.
REQ-032 SHALL verify single frame: WIDTH=8, MSB_FIRST=1, d=8'b1001_0110 accepted with shift_en=1 -> sout=1,0,0,1,0,1,1,0 on 8 consecutive cycles, first on bit 1, done on bit 8, then IDLE.
REQ-033 SHALL verify LSB-first order: MSB_FIRST=0, d=8'hA5 -> sout=1,0,1,0,0,1,0,1.
REQ-034 SHALL verify back-to-back: 8'hF0 then 8'h0F offered with load_valid held high -> 16 contiguous valid bits, second accept in the done cycle, first asserted on cycles 1 and 9.
REQ-035 SHALL verify stall: shift_en=0 for 3 cycles after bit 3 -> bit 3 held for 4 cycles total, frame completes with the correct remaining bits, and load_ready stays 0 during the stall.
REQ-036 SHALL verify reset mid-frame: rst pulsed during bit 5 -> outputs 0 immediately; new word 8'h3C afterwards transmits correctly from bit 1.
